// File: rtl/sbox_share_arbiter_if.sv
// Request/response bundle for the shared S-box column.
// master = requesters (round datapath + key expansion), slave = arbiter.
interface sbox_share_arbiter_if;
  logic         st_req_valid;
  logic         st_req_ready;
  logic [127:0] st_req_data;
  logic         st_rsp_valid;
  logic [127:0] st_rsp_data;
  logic         ky_req_valid;
  logic         ky_req_ready;
  logic [31:0]  ky_req_data;
  logic         ky_rsp_valid;
  logic [31:0]  ky_rsp_data;
  logic         busy;

  modport master (
    output st_req_valid, st_req_data,
    output ky_req_valid, ky_req_data,
    input  st_req_ready, st_rsp_valid, st_rsp_data,
    input  ky_req_ready, ky_rsp_valid, ky_rsp_data,
    input  busy
  );

  modport slave (
    input  st_req_valid, st_req_data,
    input  ky_req_valid, ky_req_data,
    output st_req_ready, st_rsp_valid, st_rsp_data,
    output ky_req_ready, ky_rsp_valid, ky_rsp_data,
    output busy
  );
endinterface

// File: rtl/sbox_share_arbiter.sv
// One 4-byte S-box column shared by a 4-beat SubBytes job and SubWord.
// Optional SBOX_SHARE_PERF_EN adds stall_cnt (key-stolen beat slots).
module sbox_share_arbiter #(
  parameter int KEY_PRIORITY = 1
) (
  input  logic clk,
  input  logic rst,
  sbox_share_arbiter_if.slave bus
`ifdef SBOX_SHARE_PERF_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic {S_IDLE, S_BEAT} state_t;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  // inverse as x^254 (0 maps to 0), then the AES affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] t;
    logic [7:0] r;
    t = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t = gmul(t, t);
      r = gmul(r, t);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_col(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

  state_t             r_state;
  logic [1:0]         r_cnt;
  logic               r_ptr_key;
  logic [3:0][31:0]   r_in;
  logic [2:0][31:0]   r_out;
  logic               r_st_rsp_valid;
  logic [127:0]       r_st_rsp_data;
  logic               r_ky_rsp_valid;
  logic [31:0]        r_ky_rsp_data;

  logic        w_idle;
  logic        w_st_ready;
  logic        w_ky_ready;
  logic        w_ky_grant;
  logic        w_st_grant;
  logic        w_st_acc;
  logic [31:0] w_col_in;
  logic [31:0] w_col_out;

  assign w_idle     = (r_state == S_IDLE);
  assign w_st_ready = ~rst & w_idle;
  // key readiness never looks at st_req_valid: the state side always
  // wants the slot while in BEAT
  assign w_ky_ready = ~rst & (w_idle | (KEY_PRIORITY != 0) | r_ptr_key);
  assign w_ky_grant = bus.ky_req_valid & w_ky_ready;
  assign w_st_grant = ~w_idle & ~w_ky_grant;
  assign w_st_acc   = bus.st_req_valid & w_st_ready;

  assign w_col_in  = w_ky_grant ? bus.ky_req_data : r_in[r_cnt];
  assign w_col_out = sub_col(w_col_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= 2'd0;
      r_ptr_key      <= 1'b0;
      r_in           <= '0;
      r_out          <= '0;
      r_st_rsp_valid <= 1'b0;
      r_st_rsp_data  <= '0;
      r_ky_rsp_valid <= 1'b0;
      r_ky_rsp_data  <= '0;
    end else begin
      r_st_rsp_valid <= 1'b0;
      r_ky_rsp_valid <= w_ky_grant;
      if (w_ky_grant) r_ky_rsp_data <= w_col_out;
      unique case (r_state)
        S_IDLE: begin
          if (w_st_acc) begin
            r_in    <= bus.st_req_data;
            r_cnt   <= 2'd0;
            r_state <= S_BEAT;
          end
        end
        S_BEAT: begin
          if (w_st_grant) begin
            r_cnt <= r_cnt + 2'd1;
            unique case (r_cnt)
              2'd0: r_out[0] <= w_col_out;
              2'd1: r_out[1] <= w_col_out;
              2'd2: r_out[2] <= w_col_out;
              2'd3: begin
                r_st_rsp_data  <= {w_col_out, r_out};
                r_st_rsp_valid <= 1'b1;
                r_state        <= S_IDLE;
              end
            endcase
          end
        end
      endcase
      // every slot with a waiting key is contended; winner was r_ptr_key
      if (KEY_PRIORITY == 0 && !w_idle && bus.ky_req_valid)
        r_ptr_key <= ~r_ptr_key;
    end
  end

  assign bus.st_req_ready = w_st_ready;
  assign bus.ky_req_ready = w_ky_ready;
  assign bus.st_rsp_valid = r_st_rsp_valid;
  assign bus.st_rsp_data  = r_st_rsp_data;
  assign bus.ky_rsp_valid = r_ky_rsp_valid;
  assign bus.ky_rsp_data  = r_ky_rsp_data;
  assign bus.busy         = ~w_idle;

`ifdef SBOX_SHARE_PERF_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall_cnt <= 16'd0;
    else if (!w_idle && w_ky_grant && r_stall_cnt != 16'hFFFF)
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/sbox_share_arbiter.md
Name: sbox_share_arbiter

Overview:
Time-multiplexes one 4-byte S-box column (a single subBytesCol instance, 4 S-boxes) between two requesters.
- State requester: the AES round datapath, which needs a full 128-bit SubBytes.
- Key requester: key expansion, which needs a 32-bit SubWord.
A 128-bit job is processed as four column beats. Key words are slotted between beats according to a priority policy. The block replaces the 16-S-box subBytes in area-reduced builds.

Parameters:
KEY_PRIORITY, 1, 1 = key requester has fixed priority over state beats; 0 = round-robin between key and state beat when both contend.

Ports:
clk  in  1  clock; all logic rising-edge.
rst  in  1  asynchronous, active-high reset.
st_req_valid  in  1  state job request.
st_req_ready  out  1  state job accepted when valid&ready.
st_req_data  in  128  state in; column i = bits [32i +: 32].
st_rsp_valid  out  1  one-cycle pulse, result valid; no backpressure.
st_rsp_data  out  128  SubBytes(state), same column mapping.
ky_req_valid  in  1  key word request.
ky_req_ready  out  1  key word accepted when valid&ready.
ky_req_data  in  32  word to substitute.
ky_rsp_valid  out  1  one-cycle pulse.
ky_rsp_data  out  32  SubWord(ky_req_data).
busy  out  1  state engine not IDLE.

Behaviour:
Reset values (async, immediate):
- All outputs 0.
- FSM = IDLE, beat counter = 0, round-robin pointer = state.
- Data registers 0.

State FSM (IDLE, BEAT):
- st_req_ready = (FSM == IDLE).
- Accept in IDLE at cycle T: capture st_req_data into in-buffer; go to BEAT with cnt = 0.
- In BEAT, each cycle is a slot.
  - Granted to state: column cnt is driven into the S-box column and the result is written into out-buffer column cnt; cnt += 1.
  - Granted to key: cnt holds (stall).
- Grant on beat cnt = 3 → FSM returns to IDLE. st_rsp_valid = 1 next cycle with full out-buffer on st_rsp_data.
- Zero-stall latency: accept T, rsp_valid at T+5. Each stall adds 1 cycle.
- st_rsp_data holds its value until the next rsp. st_rsp_valid is high exactly one cycle.
- Back-to-back: the rsp cycle is IDLE, so a new job may be accepted in the same cycle st_rsp_valid is high.

Key path:
- Accepted word goes through the S-box column in the acceptance cycle, directly from ky_req_data.
- Result is registered: ky_rsp_valid at T+1, ky_rsp_data held until next rsp.
- Key never waits in a buffer. Either it is accepted and served in the same cycle, or ready is low.

Slot arbitration:
- FSM IDLE: ky_req_ready = 1.
- FSM BEAT, KEY_PRIORITY = 1: ky_req_ready = 1; the key steals the slot and the state beat stalls.
  - Continuous key traffic starves the state job indefinitely. This is permitted; upstream key schedule is bursty.
- FSM BEAT, KEY_PRIORITY = 0, both contending: grant alternates via the RR pointer.
  - Pointer flips to the other side after each contended grant.
  - Uncontended slots do not move the pointer.
  - Guarantees a state job finishes within 8 BEAT cycles.
- ky_req_ready must not depend on st_req_valid; it depends only on FSM and pointer.

Other rules:
- Simultaneous st accept and key accept in IDLE: both proceed, since the state capture does not use the S-box.
- Reset mid-job: job dropped, no rsp pulse, any in-flight key rsp suppressed.
- S-box column mux select comes from registers (FSM, cnt, pointer) plus ky_req_valid only. No combinational path from st_req_valid to any output.

Optional Feature:
Macro SBOX_SHARE_PERF_EN.
- Defined: adds output port stall_cnt (out, 16). Increments on each BEAT cycle where the state beat is stalled by a key grant. Saturates at 0xFFFF; reset to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
1. Reset, st_req 128'h0 accepted at T, no key traffic → st_rsp_valid only at T+5, st_rsp_data = 128'h6363…63; busy high T+1..T+4.
2. IDLE, ky_req_data 32'h0153_01FF → ky_rsp_valid T+1, ky_rsp_data 32'h7CED_7C16.
3. KEY_PRIORITY = 1: state job of all 8'h53 at T, key valid T+2..T+3 with 32'h0101_0101 → two key rsps 32'h7C7C_7C7C at T+3 and T+4; st_rsp_valid at T+7 with all 8'hED; stall_cnt = 2 when PERF_EN.
4. KEY_PRIORITY = 0: key valid continuously during a state job → grants alternate; st_rsp_valid by T+9; key ready toggles 1,0,1,0.
5. Assert rst at T+3 of a state job → all outputs 0 immediately, no st_rsp_valid; new job afterward completes normally in 5 cycles.
6. Back-to-back state jobs A then B, B accepted in A's rsp cycle → rsps exactly 5 cycles apart with correct data.
